// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and the shared datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic       instr_done;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
        output instr_done, illegal_instr, state
    );

    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
        input  instr_done, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of a multicycle RV32I core: datapath selects are registered per state,
// write strobes are decoded from state plus the same-cycle mem_ready/zero inputs.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
    } sel_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam sel_t FETCH_SEL = '{adr_src: 1'b0, result_src: 2'b10, alu_src_a: 2'b00,
                                   alu_src_b: 2'b10, alu_control: ALU_ADD};

    function automatic logic [3:0] alu_decode(input logic op5, input logic [2:0] f3,
                                              input logic f75);
        case (f3)
            3'b000:  return (op5 && f75) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return f75 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;  // sltu is not supported and quietly adds
        endcase
    endfunction

    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return MEMADR;
            OP_RTYPE:          return EXECUTER;
            OP_ITYPE:          return EXECUTEI;
            OP_BRANCH:         return BRANCH;
            OP_JAL:            return JAL;
            default:           return FETCH;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                          input logic ready);
        case (s)
            FETCH:    return ready ? DECODE : FETCH;
            DECODE:   return decode_target(op);
            MEMADR:   return op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  return ready ? MEMWB : MEMREAD;
            MEMWRITE: return ready ? FETCH : MEMWRITE;
            EXECUTER: return ALUWB;
            EXECUTEI: return ALUWB;
            JAL:      return ALUWB;
            default:  return FETCH;  // MEMWB, ALUWB, BRANCH and unreachable codes
        endcase
    endfunction

    function automatic sel_t sel_for(input state_t s, input logic [3:0] alu_op);
        sel_t v;
        v = '0;
        case (s)
            FETCH:    v = FETCH_SEL;
            DECODE:   begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b01; end
            MEMADR:   begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; end
            MEMREAD:  v.adr_src = 1'b1;
            MEMWB:    v.result_src = 2'b01;
            MEMWRITE: v.adr_src = 1'b1;
            EXECUTER: begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b00; v.alu_control = alu_op; end
            EXECUTEI: begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; v.alu_control = alu_op; end
            BRANCH:   begin v.alu_src_a = 2'b10; v.alu_control = ALU_SUB; end
            JAL:      begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; end
            default:  v = '0;  // ALUWB selects ALUOut, all zero
        endcase
        return v;
    endfunction

    state_t state_q;
    state_t state_d;
    sel_t   sel_q;

    assign state_d = next_state(state_q, bus.op, bus.mem_ready);

    // Selects are registered from the next state so each state's mux settings
    // are stable from the start of its cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            sel_q   <= FETCH_SEL;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_for(state_d, alu_decode(bus.op[5], bus.funct3, bus.funct7_5));
        end
    end

    logic pc_write, mem_write, ir_write, reg_write, done, illegal;

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        pc_write  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
            end
            DECODE: begin
                if (decode_target(bus.op) == FETCH) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end
            end
            MEMWB, ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                done      = bus.mem_ready;
            end
            BRANCH: begin
                done = 1'b1;
                case (bus.funct3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = ~bus.zero;
                    default: illegal  = 1'b1;
                endcase
            end
            JAL:     pc_write = 1'b1;
            default: ;
        endcase
        // Strobes are masked while reset is held so an aborted instruction writes nothing.
        if (!rst_n) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            done      = 1'b0;
            illegal   = 1'b0;
        end
    end

    sel_t sel_out;
    assign sel_out = rst_n ? sel_q : FETCH_SEL;

    assign bus.PCWrite       = pc_write;
    assign bus.MemWrite      = mem_write;
    assign bus.IRWrite       = ir_write;
    assign bus.RegWrite      = reg_write;
    assign bus.instr_done    = done;
    assign bus.illegal_instr = illegal;
    assign bus.AdrSrc        = sel_out.adr_src;
    assign bus.ResultSrc     = sel_out.result_src;
    assign bus.ALUSrcA       = sel_out.alu_src_a;
    assign bus.ALUSrcB       = sel_out.alu_src_b;
    assign bus.ALUControl    = sel_out.alu_control;
    assign bus.state         = rst_n ? state_q : FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded into an
// expected per-cycle trace from its class, then driven cycle by cycle and compared.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        obs_t e;
        logic mr;
        logic rst;
    } step_t;

    int vectors = 0;
    int miscompares = 0;

    function automatic obs_t observe();
        obs_t o;
        o.state       = bus.state;
        o.pc_write    = bus.PCWrite;
        o.adr_src     = bus.AdrSrc;
        o.mem_write   = bus.MemWrite;
        o.ir_write    = bus.IRWrite;
        o.reg_write   = bus.RegWrite;
        o.result_src  = bus.ResultSrc;
        o.alu_src_a   = bus.ALUSrcA;
        o.alu_src_b   = bus.ALUSrcB;
        o.alu_control = bus.ALUControl;
        o.instr_done  = bus.instr_done;
        o.illegal     = bus.illegal_instr;
        return o;
    endfunction

    // ---------------- reference model ----------------
    function automatic obs_t blank(input int st);
        obs_t o;
        o = '0;
        o.state = 4'(st);
        return o;
    endfunction

    function automatic obs_t fetch_cycle(input logic ready);
        obs_t o;
        o = blank(0);
        o.alu_src_b  = 2'b10;
        o.result_src = 2'b10;
        o.ir_write   = ready;
        o.pc_write   = ready;
        return o;
    endfunction

    function automatic logic [3:0] expected_alu(input logic [6:0] op, input logic [2:0] f3,
                                                input logic f75);
        case (f3)
            3'd0: return (op == 7'b0110011 && f75) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd4: return 4'd4;
            3'd5: return f75 ? 4'd8 : 4'd7;
            3'd6: return 4'd3;
            3'd7: return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the full expected trace of one instruction starting in FETCH.
    task automatic build_trace(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                               input logic z, input int fstall, input int mstall,
                               output step_t q[$]);
        obs_t o;
        obs_t wb;
        q = {};
        for (int i = 0; i < fstall; i++) q.push_back('{fetch_cycle(1'b0), 1'b0, 1'b1});
        q.push_back('{fetch_cycle(1'b1), 1'b1, 1'b1});
        o = blank(1);
        o.alu_src_a = 2'b01;
        o.alu_src_b = 2'b01;
        wb = blank(8);
        wb.reg_write = 1'b1;
        wb.instr_done = 1'b1;
        case (op)
            7'b0000011, 7'b0100011: begin
                q.push_back('{o, rnd_bit(), 1'b1});
                o = blank(2);
                o.alu_src_a = 2'b10;
                o.alu_src_b = 2'b01;
                q.push_back('{o, rnd_bit(), 1'b1});
                if (op[5]) begin
                    o = blank(5);
                    o.adr_src = 1'b1;
                    o.mem_write = 1'b1;
                    for (int i = 0; i < mstall; i++) q.push_back('{o, 1'b0, 1'b1});
                    o.instr_done = 1'b1;
                    q.push_back('{o, 1'b1, 1'b1});
                end else begin
                    o = blank(3);
                    o.adr_src = 1'b1;
                    for (int i = 0; i < mstall; i++) q.push_back('{o, 1'b0, 1'b1});
                    q.push_back('{o, 1'b1, 1'b1});
                    o = blank(4);
                    o.result_src = 2'b01;
                    o.reg_write = 1'b1;
                    o.instr_done = 1'b1;
                    q.push_back('{o, rnd_bit(), 1'b1});
                end
            end
            7'b0110011, 7'b0010011: begin
                q.push_back('{o, rnd_bit(), 1'b1});
                o = blank(op[5] ? 6 : 7);
                o.alu_src_a = 2'b10;
                o.alu_src_b = op[5] ? 2'b00 : 2'b01;
                o.alu_control = expected_alu(op, f3, f75);
                q.push_back('{o, rnd_bit(), 1'b1});
                q.push_back('{wb, rnd_bit(), 1'b1});
            end
            7'b1100011: begin
                q.push_back('{o, rnd_bit(), 1'b1});
                o = blank(9);
                o.alu_src_a = 2'b10;
                o.alu_control = 4'd1;
                o.instr_done = 1'b1;
                o.pc_write = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
                o.illegal = (f3 != 3'd0 && f3 != 3'd1);
                q.push_back('{o, rnd_bit(), 1'b1});
            end
            7'b1101111: begin
                q.push_back('{o, rnd_bit(), 1'b1});
                o = blank(10);
                o.alu_src_a = 2'b01;
                o.alu_src_b = 2'b10;
                o.pc_write = 1'b1;
                q.push_back('{o, rnd_bit(), 1'b1});
                q.push_back('{wb, rnd_bit(), 1'b1});
            end
            default: begin
                o.illegal = 1'b1;
                o.instr_done = 1'b1;
                q.push_back('{o, rnd_bit(), 1'b1});
            end
        endcase
    endtask

    // Drives one cycle's inputs just after a rising edge and waits for the falling edge.
    task automatic drive_step(input step_t s);
        bus.mem_ready = s.mr;
        rst_n = s.rst;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic z, input int fstall, input int mstall);
        step_t q[$];
        obs_t got;
        build_trace(op, f3, f75, z, fstall, mstall, q);
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7_5 = f75;
        bus.zero = z;
        foreach (q[i]) begin
            drive_step(q[i]);
            got = observe();
            vectors++;
            if (got !== q[i].e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got state=%0d fields=%h, want state=%0d fields=%h",
                         name, i, got.state, got, q[i].e.state, q[i].e);
            end
            next_edge();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t got;
        for (int i = 0; i < 3; i++) begin
            drive_step('{fetch_cycle(1'b0), 1'b1, 1'b0});
            got = observe();
            vectors++;
            if (got !== fetch_cycle(1'b0)) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h want %h", i, got, fetch_cycle(1'b0));
            end
            next_edge();
        end
        run_instr("post_reset_add", 7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_rtype_sub();
        run_instr("rtype_sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_imm_decode();
        run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("srai", 7'b0010011, 3'd5, 1'b1, 1'b0, 0, 0);
        run_instr("srli", 7'b0010011, 3'd5, 1'b0, 1'b0, 0, 0);
        run_instr("sltu_r", 7'b0110011, 3'd3, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_load_stall();
        run_instr("load_stall2", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 2);
        run_instr("load_fetch_stall", 7'b0000011, 3'd2, 1'b0, 1'b0, 2, 0);
    endtask

    task automatic test_store_stall();
        run_instr("store_stall1", 7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr("bne_zero", 7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr("bne_nonzero", 7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("branch_f3_100", 7'b1100011, 3'd4, 1'b0, 1'b0, 0, 0);
        run_instr("illegal_op", 7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
    endtask

    // Reset lands while a store is stalled; no strobe may escape and FETCH follows.
    task automatic test_reset_abort();
        step_t q[$];
        obs_t got;
        obs_t mw;
        build_trace(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1, q);
        mw = q[3].e;
        q = q[0:3];
        q.push_back('{fetch_cycle(1'b0), 1'b1, 1'b0});
        q.push_back('{fetch_cycle(1'b0), 1'b0, 1'b1});
        bus.op = 7'b0100011;
        bus.funct3 = 3'd2;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        foreach (q[i]) begin
            drive_step(q[i]);
            got = observe();
            vectors++;
            if (got !== q[i].e) begin
                miscompares++;
                $display("FAIL reset_abort cycle %0d: got %h want %h (stalled store %h)",
                         i, got, q[i].e, mw);
            end
            next_edge();
        end
    endtask

    task automatic test_back_to_back_random();
        logic [6:0] ops [8];
        logic [6:0] op;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) op = 7'($urandom_range(0, 127));
            run_instr("random", op, 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        bus.op = '0;
        bus.funct3 = '0;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype_sub();
        test_imm_decode();
        test_load_stall();
        test_store_stall();
        test_branch();
        test_reset_abort();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for a multicycle RV32I core sharing one ALU and one memory port across all instruction phases. Each cycle it sequences the ALU operand muxes, ALU operation, result mux, memory address source and all architectural write strobes. It decodes the ALU operation internally using the codebase's 4-bit ALUControl encoding. It sits between the instruction register and the shared datapath.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- op  in  7  instruction opcode bits [6:0], from instruction register
- funct3  in  3  instruction bits [14:12]
- funct7_5  in  1  instruction bit 30
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory port completes the current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00=ALUOut reg, 01=read data, 10=ALU result
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_instr  out  1  one-cycle pulse on unsupported opcode or branch funct3
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10. Encodings 11–15 are unreachable and go to FETCH.
- Outputs are Moore functions of state, except where a strobe below names an input. Fields not listed are 0 / 0000.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, IRWrite=mem_ready, PCWrite=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, add (branch/JAL target into ALUOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL.
  - Any other op -> FETCH, with illegal_instr=1 and instr_done=1.
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, add.
  - Goes to MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- MEMWRITE
  - Outputs: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in this state, instr_done=mem_ready.
  - Holds until mem_ready, then goes to FETCH.
- EXECUTER
  - Outputs: ALUSrcA=10, ALUSrcB=00, decoded ALUControl.
  - Goes to ALUWB.
- EXECUTEI
  - Outputs: ALUSrcA=10, ALUSrcB=01, decoded ALUControl.
  - Goes to ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done=1.
  - funct3=000 (beq): PCWrite=zero.
  - funct3=001 (bne): PCWrite=~zero.
  - Other funct3: PCWrite=0 and illegal_instr=1.
  - Goes to FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, add (OldPC+4 into ALUOut), ResultSrc=00 (target), PCWrite=1.
  - Goes to ALUWB, which writes rd.
- ALU decode for EXECUTER/EXECUTEI, by funct3:
  - 000: sub only if op[5]=1 and funct7_5=1; otherwise add.
  - 001: sll. 010: slt. 100: xor. 110: or. 111: and.
  - 101: sra if funct7_5=1, else srl.
  - 011 (sltu, unsupported): add, and no illegal flag.
- op, funct3 and funct7_5 are sampled only in states after FETCH. They are stable because IRWrite is 0 outside FETCH.

## Timing
- rst_n=0 at a rising edge sets state=FETCH.
- While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_instr are forced to 0. All other outputs show FETCH values.
- Reset asserted mid-instruction aborts it: no write strobe is asserted in the cycle reset is sampled low. The first cycle after release is FETCH.
- Latency with mem_ready constantly 1:
  - Load: 5 cycles. Store: 4. R-type: 4. I-type: 4. JAL: 4. Branch: 3. Illegal opcode: 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle and repeats that state's outputs.
- In FETCH and MEMWRITE, mem_ready is combinational to strobes; no registered delay.
- Exactly one instr_done pulse per fetched instruction, including illegal ones.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> state=0; PCWrite, IRWrite, MemWrite and RegWrite are 0 every cycle; first post-release cycle has IRWrite=1.
- R-type sub (op=0110011, funct3=000, funct7_5=1) -> state sequence 0,1,6,8,0; ALUControl=0001 in EXECUTER; RegWrite=1 only in ALUWB; instr_done asserted once.
- addi with funct7_5=1 (op=0010011, funct3=000) -> ALUControl=0000; srai (funct3=101, funct7_5=1) -> 1000; srli (funct7_5=0) -> 0111.
- Load with mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; RegWrite=1 with ResultSrc=01 only in MEMWB.
- Store (op=0100011) with mem_ready=0 for 1 cycle -> MemWrite=1 for 2 cycles, AdrSrc=1; instr_done only on the mem_ready=1 cycle.
- beq with zero=1 -> PCWrite=1 in BRANCH; bne with zero=1 -> PCWrite=0; funct3=100 -> PCWrite=0 and illegal_instr=1; op=1111111 -> DECODE goes to FETCH with illegal_instr=1.
